// File: rtl/voxel_ray_traverser_pkg.sv
// Shared types for the voxel ray traverser and the chunk block-lookup interface.
package voxel_ray_traverser_pkg;

  localparam int POS_W       = 8;
  localparam int CHUNK_WIDTH = 16;

  typedef struct packed {
    logic signed [POS_W-1:0] z;
    logic signed [POS_W-1:0] y;
    logic signed [POS_W-1:0] x;
  } BlockPos;

  typedef enum logic [3:0] {
    BLOCK_AIR   = 4'd0,
    BLOCK_STONE = 4'd1,
    BLOCK_DIRT  = 4'd2,
    BLOCK_GRASS = 4'd3
  } BlockType;

  // Encoding is 1 + 2*axis + (step was -1), which the traverser relies on.
  typedef enum logic [2:0] {
    FACE_NONE  = 3'd0,
    FACE_NEG_X = 3'd1,
    FACE_POS_X = 3'd2,
    FACE_NEG_Y = 3'd3,
    FACE_POS_Y = 3'd4,
    FACE_NEG_Z = 3'd5,
    FACE_POS_Z = 3'd6
  } Face;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_STEP,
    ST_DONE
  } trav_state_e;

endpackage

// File: rtl/voxel_ray_traverser_dda_axis_select.sv
// Combinational argmin over three t_max values, ties resolved x, then y, then z.
module dda_axis_select
  import voxel_ray_traverser_pkg::*;
#(
  parameter int T_WIDTH = 24
) (
  input  logic [T_WIDTH-1:0] t_x_i,
  input  logic [T_WIDTH-1:0] t_y_i,
  input  logic [T_WIDTH-1:0] t_z_i,
  output logic [1:0]         axis_o,
  output logic               all_ones_o
);

  logic [T_WIDTH-1:0] t_min;

  always_comb begin
    if (t_x_i <= t_y_i && t_x_i <= t_z_i) begin
      axis_o = 2'd0;
      t_min  = t_x_i;
    end else if (t_y_i <= t_z_i) begin
      axis_o = 2'd1;
      t_min  = t_y_i;
    end else begin
      axis_o = 2'd2;
      t_min  = t_z_i;
    end
  end

  // An all-ones minimum means no axis has a finite boundary left.
  assign all_ones_o = &t_min;

endmodule

// File: rtl/voxel_ray_traverser.sv
// Amanatides-Woo DDA ray walker driving the chunk block-lookup interface.
// Optional macro RAYCAST_ABORT_EN adds abort_in to cancel an in-flight ray.
module voxel_ray_traverser
  import voxel_ray_traverser_pkg::*;
#(
  parameter int  T_WIDTH   = 24,
  parameter int  MAX_STEPS = 128,
  localparam int STEP_W    = $clog2(MAX_STEPS + 1)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  BlockPos                origin,
  input  logic [2:0]             step_neg,
  input  logic [3*T_WIDTH-1:0]   t_max_init,
  input  logic [3*T_WIDTH-1:0]   t_delta,
  output BlockPos                lookup_addr,
  output logic                   lookup_read_enable,
  input  BlockType               lookup_out,
  input  logic                   lookup_valid,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   result_hit,
  output BlockPos                result_pos,
  output BlockType               result_block,
  output Face                    result_face,
  output logic [STEP_W-1:0]      result_steps
`ifdef RAYCAST_ABORT_EN
  ,
  input  logic                   abort_in
`endif
);

  trav_state_e state_q, state_d;
  BlockPos     pos_q, pos_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  Face         face_q, face_d;
  logic        hit_q, hit_d;
  BlockType    block_q, block_d;

  logic [2:0][T_WIDTH-1:0] tmax_q, tmax_d, tdel_q;
  logic [2:0]              neg_q;

  logic [1:0]              sel_axis;
  logic                    sel_ones;
  logic [2:0][POS_W-1:0]   pos_arr, pos_nxt_arr;
  logic signed [POS_W-1:0] cur_c;
  logic signed [POS_W:0]   nxt_c;
  logic                    out_of_chunk;

  function automatic logic [T_WIDTH-1:0] sat_add(input logic [T_WIDTH-1:0] a,
                                                 input logic [T_WIDTH-1:0] b);
    logic [T_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[T_WIDTH] ? '1 : s[T_WIDTH-1:0];
  endfunction

  dda_axis_select #(.T_WIDTH(T_WIDTH)) u_sel (
    .t_x_i      (tmax_q[0]),
    .t_y_i      (tmax_q[1]),
    .t_z_i      (tmax_q[2]),
    .axis_o     (sel_axis),
    .all_ones_o (sel_ones)
  );

  // Stepped coordinate is formed one bit wider so the chunk-exit test cannot wrap.
  assign pos_arr = pos_q;
  assign cur_c   = pos_arr[sel_axis];
  assign nxt_c   = {cur_c[POS_W-1], cur_c} +
                   (neg_q[sel_axis] ? {(POS_W+1){1'b1}} : (POS_W+1)'(1));
  assign out_of_chunk = neg_q[sel_axis] ? (int'(nxt_c) < -CHUNK_WIDTH)
                                        : (int'(nxt_c) >= CHUNK_WIDTH);

  always_comb begin
    pos_nxt_arr           = pos_arr;
    pos_nxt_arr[sel_axis] = nxt_c[POS_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    steps_d = steps_q;
    face_d  = face_q;
    hit_d   = hit_q;
    block_d = block_q;
    tmax_d  = tmax_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          state_d = ST_LOOKUP;
          pos_d   = origin;
          steps_d = '0;
          face_d  = FACE_NONE;
          hit_d   = 1'b0;
          block_d = BLOCK_AIR;
          tmax_d  = t_max_init;
        end
      end
      ST_LOOKUP: begin
        if (lookup_valid) begin
          if (lookup_out != BLOCK_AIR) begin
            block_d = lookup_out;
            hit_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_STEP;
          end
        end
      end
      ST_STEP: begin
        if (sel_ones) begin
          state_d = ST_DONE;
        end else begin
          pos_d            = BlockPos'(pos_nxt_arr);
          tmax_d[sel_axis] = sat_add(tmax_q[sel_axis], tdel_q[sel_axis]);
          steps_d          = steps_q + STEP_W'(1);
          face_d           = Face'({sel_axis, 1'b0} + {2'b00, neg_q[sel_axis]} + 3'd1);
          if (out_of_chunk || steps_d == STEP_W'(MAX_STEPS)) state_d = ST_DONE;
          else                                               state_d = ST_LOOKUP;
        end
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef RAYCAST_ABORT_EN
    if (abort_in && state_q != ST_IDLE) state_d = ST_IDLE;
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      steps_q <= '0;
      face_q  <= FACE_NONE;
      hit_q   <= 1'b0;
      block_q <= BLOCK_AIR;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      steps_q <= steps_d;
      face_q  <= face_d;
      hit_q   <= hit_d;
      block_q <= block_d;
    end
  end

  always_ff @(posedge clk_in) begin
    tmax_q <= tmax_d;
    if (state_q == ST_IDLE && start_valid) begin
      tdel_q <= t_delta;
      neg_q  <= step_neg;
    end
  end

  assign start_ready        = (state_q == ST_IDLE);
  assign lookup_read_enable = (state_q == ST_LOOKUP);
  assign lookup_addr        = pos_q;
  assign result_valid       = (state_q == ST_DONE);
  assign result_hit         = hit_q;
  assign result_pos         = pos_q;
  assign result_block       = block_q;
  assign result_face        = face_q;
  assign result_steps       = steps_q;

endmodule
